// File: rtl/entrada_pkg.sv
// rtl/entrada_pkg.sv - shared types and default constants for the Entrada input stage
// Purpose: FSM state encoding and default parameter values used by modulo_entrada_chaves.
// Ports: none (package).
package entrada_pkg;

    typedef enum logic [1:0] {
        OCIOSO        = 2'd0,
        DEB_PRESS     = 2'd1,
        ESPERA_SOLTAR = 2'd2,
        DEB_SOLTA     = 2'd3
    } estado_t;

    // 10 ms at 50 MHz
    localparam int DEBOUNCE_CYCLES_DEF = 500000;
    localparam int SW_W_DEF            = 16;

endpackage

// File: rtl/sincronizador.sv
// rtl/sincronizador.sv - two-flop synchronizer with configurable reset value
// Purpose: brings asynchronous inputs into the clk domain.
// Ports:
//   clk    input          sampling clock
//   reset  input          asynchronous, active-low reset (flops load RST_VAL)
//   d      input  WIDTH   asynchronous input
//   q      output WIDTH   synchronized output
module sincronizador #(
    parameter int                 WIDTH   = 1,
    parameter logic [WIDTH-1:0]   RST_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/modulo_entrada_chaves.sv
// rtl/modulo_entrada_chaves.sv - debounced push-button capture of the slide switches
// Purpose: synchronizes and debounces the active-low ent button; each confirmed press
//   captures the synchronized switches into a holding buffer read via valido/ler.
//   Macro ENTRADA_FIFO_EN replaces the single holding register with a FIFO_DEPTH FIFO.
// Ports:
//   clk0      input          board clock
//   reset     input          asynchronous, active-low reset
//   ent       input          raw push button, pressed = 0
//   switch    input  SW_W    raw slide switches
//   ler       input          consumer read strobe, one cycle per word
//   dado      output SW_W    head word of the buffer
//   valido    output         dado holds an unread word
//   overflow  output         sticky, a confirmed press was dropped (buffer full)
//   ocupado   output         FSM not in OCIOSO
module modulo_entrada_chaves
    import entrada_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int CNT_W           = 20,
    parameter int SW_W            = SW_W_DEF,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic            clk0,
    input  logic            reset,
    input  logic            ent,
    input  logic [SW_W-1:0] switch,
    input  logic            ler,
    output logic [SW_W-1:0] dado,
    output logic            valido,
    output logic            overflow,
    output logic            ocupado
);

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
        (64'd1 << CNT_W) <= 64'(DEBOUNCE_CYCLES)) begin : g_param_invalido
        $error("modulo_entrada_chaves: invalid FIFO_DEPTH or CNT_W");
    end

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic            ent_s;
    logic [SW_W-1:0] sw_s;

    sincronizador #(.WIDTH(1), .RST_VAL(1'b1)) u_sync_ent (
        .clk   (clk0),
        .reset (reset),
        .d     (ent),
        .q     (ent_s)
    );

    sincronizador #(.WIDTH(SW_W), .RST_VAL('0)) u_sync_sw (
        .clk   (clk0),
        .reset (reset),
        .d     (switch),
        .q     (sw_s)
    );

    estado_t          estado, estado_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             captura;

    // Resetting into ESPERA_SOLTAR means a button held through reset release
    // must first be released and debounced before any capture is possible.
    always_ff @(posedge clk0 or negedge reset) begin
        if (!reset) begin
            estado <= ESPERA_SOLTAR;
            cnt    <= '0;
        end else begin
            estado <= estado_nx;
            cnt    <= cnt_nx;
        end
    end

    always_comb begin
        estado_nx = estado;
        cnt_nx    = cnt;
        captura   = 1'b0;
        case (estado)
            OCIOSO: begin
                if (!ent_s) begin
                    estado_nx = DEB_PRESS;
                    cnt_nx    = '0;
                end
            end
            DEB_PRESS: begin
                if (ent_s) begin
                    estado_nx = OCIOSO;
                    cnt_nx    = '0;
                end else if (cnt == CNT_MAX) begin
                    captura   = 1'b1;
                    estado_nx = ESPERA_SOLTAR;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            ESPERA_SOLTAR: begin
                if (ent_s) begin
                    estado_nx = DEB_SOLTA;
                    cnt_nx    = '0;
                end
            end
            DEB_SOLTA: begin
                if (!ent_s) begin
                    estado_nx = ESPERA_SOLTAR;
                end else if (cnt == CNT_MAX) begin
                    estado_nx = OCIOSO;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            default: estado_nx = ESPERA_SOLTAR;
        endcase
    end

    assign ocupado = (estado != OCIOSO);

`ifdef ENTRADA_FIFO_EN
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [SW_W-1:0] mem [FIFO_DEPTH];
    logic [AW:0]     wr_ptr, rd_ptr;
    logic            vazio, cheio, pop, push;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign vazio = (wr_ptr == rd_ptr);
    assign cheio = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop   = ler && !vazio;
    // A pop in the same cycle frees the slot a full FIFO needs for the push.
    assign push  = captura && (!cheio || pop);

    always_ff @(posedge clk0 or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr[AW-1:0]] <= sw_s;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (captura && !push) begin
                overflow <= 1'b1;
            end
        end
    end

    assign dado   = mem[rd_ptr[AW-1:0]];
    assign valido = !vazio;
`else
    always_ff @(posedge clk0 or negedge reset) begin
        if (!reset) begin
            dado     <= '0;
            valido   <= 1'b0;
            overflow <= 1'b0;
        end else if (captura) begin
            // A read in the capture cycle frees the register for the new word.
            if (!valido || ler) begin
                dado   <= sw_s;
                valido <= 1'b1;
            end else begin
                overflow <= 1'b1;
            end
        end else if (ler && valido) begin
            valido <= 1'b0;
        end
    end
`endif

endmodule

// File: doc/modulo_entrada_chaves.md
Name: modulo_entrada_chaves

Overview:
- Upstream input stage for the processor's Entrada instruction.
- Synchronizes and debounces the active-low `ent` push button, all in the `clk0` (board clock) domain.
- On each confirmed press, captures a synchronized copy of the 16 slide switches into a holding buffer.
- The processor's input path takes the word through a `valido`/`ler` handshake, replacing raw edge sampling of `ent`.

Parameters:
- DEBOUNCE_CYCLES, 500000: `clk0` cycles the button level must stay stable to be accepted (10 ms at 50 MHz).
- CNT_W, 20: debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.
- SW_W, 16: switch/data width.
- FIFO_DEPTH, 4: buffer depth, power of two; used only with ENTRADA_FIFO_EN.

Ports:
- clk0  input  1  board clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- ent  input  1  raw push button, active-low (pressed = 0), asynchronous.
- switch  input  SW_W  raw slide switches, asynchronous.
- ler  input  1  consumer read strobe; one `clk0` cycle per word.
- dado  output  SW_W  captured word (head of buffer).
- valido  output  1  `dado` holds an unread word.
- overflow  output  1  sticky: a confirmed press was dropped because the buffer was full.
- ocupado  output  1  FSM is not in OCIOSO.

Behaviour:
- Reset: asserting `reset` (low) asynchronously clears all state, including mid-debounce and mid-press: `dado`=0, `valido`=0, `overflow`=0, debounce counter=0, synchronizer flops=1 for `ent` and 0 for `switch`.
- Reset value of `ocupado`: 1, because the FSM resets into ESPERA_SOLTAR, not OCIOSO. A button held through reset release therefore never produces a capture.
- Synchronization: `ent` and `switch` each pass through 2 flip-flops. The FSM uses only the synchronized values, `ent_s` and `sw_s`.
- FSM states: OCIOSO, DEB_PRESS, ESPERA_SOLTAR, DEB_SOLTA.
  - OCIOSO: `ent_s`=0 -> DEB_PRESS, counter cleared.
  - DEB_PRESS: counter increments while `ent_s`=0. If `ent_s`=1 (bounce) -> OCIOSO, counter cleared. When counter == DEBOUNCE_CYCLES-1 with `ent_s` still 0: capture `sw_s` (a one-cycle `captura` pulse) and go to ESPERA_SOLTAR.
  - ESPERA_SOLTAR: `ent_s`=1 -> DEB_SOLTA, counter cleared.
  - DEB_SOLTA: counter increments while `ent_s`=1. If `ent_s`=0 -> ESPERA_SOLTAR. At DEBOUNCE_CYCLES-1 -> OCIOSO.
- Latency: if `ent` falls and stays low, `valido` rises exactly DEBOUNCE_CYCLES+3 `clk0` edges later (2 synchronizer edges, DEBOUNCE_CYCLES counting edges, 1 registered load). `dado` is valid in the same cycle.
- Exactly one capture per physical press, regardless of hold time.
- Handshake:
  - `ler` with `valido`=1 consumes the word; `valido` falls on the next edge unless a capture occurs in the same cycle.
  - `ler` with `valido`=0 is ignored.
- Single-register buffer (default):
  - Capture with `valido`=0: load `dado`, set `valido`=1.
  - Capture with `valido`=1 and no `ler`: new word dropped, `dado` unchanged, `overflow`<=1.
  - Capture and `ler` in the same cycle: new word loaded, `valido` stays 1, no overflow.
- `overflow` clears only on reset.
- `switch` changes during debounce have no effect. The captured value is `sw_s` at the capture cycle.

Optional Feature:
- Macro: ENTRADA_FIFO_EN.
- When defined, the holding register is replaced by a FIFO of FIFO_DEPTH words:
  - `dado` = head entry; `valido` = not empty; `ler` pops.
  - Capture pushes.
  - Read/write pointers are log2(FIFO_DEPTH)+1 bits and wrap modulo 2*FIFO_DEPTH; full/empty are decided by the MSB comparison.
  - Push when full without `ler`: word dropped, `overflow`<=1. Push and pop in the same cycle when full: both occur, no overflow.
  - Push and pop when empty: the push takes effect and the pop is ignored.
- When not defined: single-register behaviour above. Port list is identical in both builds.

Decomposition:
- Package `entrada_pkg`: FSM state encoding (OCIOSO=2'd0, DEB_PRESS=2'd1, ESPERA_SOLTAR=2'd2, DEB_SOLTA=2'd3) and the default DEBOUNCE_CYCLES/SW_W constants.
- One sub-module `sincronizador` (parameter WIDTH, 2-stage, async active-low reset, parameterized reset value). Instantiated twice: `ent` with reset value 1, `switch` with reset value 0.
- FSM, counter and buffer live in the top.

Test Plan (bench uses DEBOUNCE_CYCLES=4):
- Release reset, `switch`=16'hA5A5, drive `ent`=0 for 20 cycles, then 1 -> `valido` rises exactly 7 edges after the `ent` fall; `dado`=16'hA5A5; exactly one capture.
- `ent` low for 2 cycles, high 1, low 2, high (bounce only) -> `valido` stays 0, `ocupado` returns to 0 after the pulses.
- Hold `ent`=0 across reset release -> `ocupado`=1 at reset release, returns to 0 only after `ent` is released and DEB_SOLTA completes; no capture.
- Two presses (16'h0001 then 16'h0002) without `ler` -> `dado`=16'h0001, `overflow`=1. Same with `ler` pulsed in the second capture cycle -> `dado`=16'h0002, `overflow`=0.
- Pulse `ler` with `valido`=0 -> no state change. Assert `reset` mid-DEB_PRESS -> all outputs at reset values immediately.
- ENTRADA_FIFO_EN: 5 presses (values 1..5) without `ler` -> `overflow`=1; four `ler` pulses return 1,2,3,4, then `valido`=0.
